// File: rtl/bbpd_decimator.sv
// Alexander bang-bang phase detector followed by a decimating up/dn vote over Ndec decisions.
// Optional macro PD_STAT_EN adds trans_cnt: transitions seen in the last closed window.
module bbpd_decimator #(
  parameter int Ndec = 8,
  parameter int Th   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       d_prev,
  input  logic       e_mid,
  input  logic       d_now,
  output logic       up,
  output logic       dn
`ifdef PD_STAT_EN
  ,
  output logic [7:0] trans_cnt
`endif
);
  localparam int Wacc = $clog2(Ndec) + 2;
  localparam int Wcnt = $clog2(Ndec);
  localparam logic signed [Wacc-1:0] TH_POS   = Wacc'(Th);
  localparam logic signed [Wacc-1:0] TH_NEG   = -TH_POS;
  localparam logic [Wcnt-1:0]        CNT_LAST = Wcnt'(Ndec - 1);

  logic                   late_q, late_d, early_q, early_d, en_d_q, en_d_d;
  logic signed [Wacc-1:0] acc_q, acc_d, vote, total;
  logic [Wcnt-1:0]        cnt_q, cnt_d;
  logic                   up_q, up_d, dn_q, dn_d;
  logic                   trans, close;

  always_comb begin
    trans   = d_prev ^ d_now;
    late_d  = en & trans & (e_mid == d_now);
    early_d = en & trans & (e_mid == d_prev);
    en_d_d  = en;

    vote = '0;
    if (late_q)
      vote = Wacc'(1);
    else if (early_q)
      vote = '1;
    total = acc_q + vote;

    // The closing decision is folded into total so the window sees all Ndec votes.
    close = en_d_q && (cnt_q == CNT_LAST);
    acc_d = acc_q;
    cnt_d = cnt_q;
    up_d  = 1'b0;
    dn_d  = 1'b0;
    if (close) begin
      acc_d = '0;
      cnt_d = '0;
      up_d  = (total > TH_POS);
      dn_d  = (total < TH_NEG);
    end else if (en_d_q) begin
      acc_d = total;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      late_q  <= 1'b0;
      early_q <= 1'b0;
      en_d_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
    end else begin
      late_q  <= late_d;
      early_q <= early_d;
      en_d_q  <= en_d_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
    end
  end

  assign up = up_q;
  assign dn = dn_q;

`ifdef PD_STAT_EN
  logic [7:0] tcnt_q, tcnt_d, tcnt_inc, trans_cnt_q, trans_cnt_d;

  // Saturating so windows longer than 255 decisions cannot wrap the count.
  always_comb begin
    tcnt_inc = tcnt_q;
    if (en_d_q && (late_q || early_q) && (tcnt_q != 8'hFF))
      tcnt_inc = tcnt_q + 8'd1;
    tcnt_d      = tcnt_inc;
    trans_cnt_d = trans_cnt_q;
    if (close) begin
      tcnt_d      = '0;
      trans_cnt_d = tcnt_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q      <= '0;
      trans_cnt_q <= '0;
    end else begin
      tcnt_q      <= tcnt_d;
      trans_cnt_q <= trans_cnt_d;
    end
  end

  assign trans_cnt = trans_cnt_q;
`endif

endmodule

// File: tb/tb_bbpd_decimator.sv
// Self-checking bench for bbpd_decimator: two instances (Th=0, Th=2) driven with the
// same directed windows and random traffic, compared against a window-list model.
module tb_bbpd_decimator;
   localparam int NDEC = 8;

   logic clk = 1'b0;
   logic clk_run = 1'b1;
   logic rst = 1'b0;
   logic en = 1'b0, d_prev = 1'b0, e_mid = 1'b0, d_now = 1'b0;
   logic up0, dn0, up2, dn2;
`ifdef PD_STAT_EN
   logic [7:0] tc0, tc2;
   int exp_tc;
`endif

   int checks = 0;
   int passes = 0;
   bit check_en = 1'b0;

   bbpd_decimator #(.Ndec(NDEC), .Th(0)) dut0 (
      .clk(clk), .rst(rst), .en(en), .d_prev(d_prev), .e_mid(e_mid), .d_now(d_now),
      .up(up0), .dn(dn0)
`ifdef PD_STAT_EN
      , .trans_cnt(tc0)
`endif
   );

   bbpd_decimator #(.Ndec(NDEC), .Th(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .d_prev(d_prev), .e_mid(e_mid), .d_now(d_now),
      .up(up2), .dn(dn2)
`ifdef PD_STAT_EN
      , .trans_cnt(tc2)
`endif
   );

   // Free-running clock that can be held low to show reset needs no edge
   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   // Reference: list of enabled decisions; every NDEC-th one closes the window
   int win [NDEC];
   int win_n = 0;
   bit pend_v = 1'b0;
   int pend_val = 0;
   bit exp_up0 = 1'b0, exp_dn0 = 1'b0, exp_up2 = 1'b0, exp_dn2 = 1'b0;

   function automatic int decide(input logic dp, input logic em, input logic dnw);
      if (dp == dnw) return 0;
      return (em == dnw) ? 1 : -1;
   endfunction

   function automatic int winSum(input int last);
      int s = last;
      for (int i = 0; i < NDEC - 1; i++) s += win[i];
      return s;
   endfunction

   function automatic int winTrans(input int last);
      int t = (last != 0) ? 1 : 0;
      for (int i = 0; i < NDEC - 1; i++) t += (win[i] != 0) ? 1 : 0;
      return (t > 255) ? 255 : t;
   endfunction

   // A decision taken at one edge is counted at the next edge
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         win_n    <= 0;
         pend_v   <= 1'b0;
         pend_val <= 0;
         exp_up0  <= 1'b0;
         exp_dn0  <= 1'b0;
         exp_up2  <= 1'b0;
         exp_dn2  <= 1'b0;
`ifdef PD_STAT_EN
         exp_tc   <= 0;
`endif
      end else begin
         exp_up0 <= 1'b0;
         exp_dn0 <= 1'b0;
         exp_up2 <= 1'b0;
         exp_dn2 <= 1'b0;
         if (pend_v) begin
            if (win_n == NDEC - 1) begin
               exp_up0 <= (winSum(pend_val) > 0);
               exp_dn0 <= (winSum(pend_val) < 0);
               exp_up2 <= (winSum(pend_val) > 2);
               exp_dn2 <= (winSum(pend_val) < -2);
`ifdef PD_STAT_EN
               exp_tc  <= winTrans(pend_val);
`endif
               win_n   <= 0;
            end else begin
               win[win_n] <= pend_val;
               win_n      <= win_n + 1;
            end
         end
         pend_v   <= en;
         pend_val <= en ? decide(d_prev, e_mid, d_now) : 0;
      end
   end

   task automatic checkOutput(input string name, input logic got_up, input logic got_dn,
                              input logic want_up, input logic want_dn);
      checks++;
      if (got_up === want_up && got_dn === want_dn)
         passes++;
      else
         $display("[TB] FAIL %s: up/dn got %b/%b, expected %b/%b at %0t",
                  name, got_up, got_dn, want_up, want_dn, $time);
   endtask

   task automatic checkCount(input string name, input int got, input int want);
      checks++;
      if (got == want)
         passes++;
      else
         $display("[TB] FAIL %s: trans_cnt got %0d, expected %0d at %0t", name, got, want, $time);
   endtask

   // Every cycle, both instances against the model
   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("cmp_th0", up0, dn0, exp_up0, exp_dn0);
         checkOutput("cmp_th2", up2, dn2, exp_up2, exp_dn2);
`ifdef PD_STAT_EN
         checkCount("cmp_tc_th0", int'(tc0), exp_tc);
         checkCount("cmp_tc_th2", int'(tc2), exp_tc);
`endif
      end
   end

   // Inputs change 1 time unit after the falling edge
   task automatic applyStimulus(input logic e, input logic dp, input logic em, input logic dnw);
      en = e;
      d_prev = dp;
      e_mid = em;
      d_now = dnw;
      @(negedge clk);
      #1;
   endtask

   task automatic sendLate(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic sendEarly(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic sendNone(input int n);
      for (int i = 0; i < n; i++) begin
         logic b;
         b = 1'($urandom_range(0, 1));
         applyStimulus(1'b1, b, 1'($urandom_range(0, 1)), b);
      end
   endtask

   task automatic padIdle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic checkBoth(input string name, input logic u0, input logic d0,
                            input logic u2, input logic d2);
      checkOutput({name, "_th0"}, up0, dn0, u0, d0);
      checkOutput({name, "_th2"}, up2, dn2, u2, d2);
   endtask

   initial begin
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      checkBoth("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      check_en = 1'b1;

      sendNone(8);  padIdle();  checkBoth("no_trans", 1'b0, 1'b0, 1'b0, 1'b0);
      sendLate(8);  padIdle();  checkBoth("all_late", 1'b1, 1'b0, 1'b1, 1'b0);

      // Asynchronous reset while the clock is held still
      clk_run = 1'b0;
      #7 rst = 1'b1;
      #1 checkBoth("imm_rst", 1'b0, 1'b0, 1'b0, 1'b0);
      #2 rst = 1'b0;
      #5 clk_run = 1'b1;
      @(negedge clk);
      #1;

      sendLate(9);  checkBoth("rep_first", 1'b1, 1'b0, 1'b1, 1'b0);
      sendLate(1);  checkBoth("rep_gap", 1'b0, 1'b0, 1'b0, 1'b0);
      sendLate(6);  padIdle();  checkBoth("rep_second", 1'b1, 1'b0, 1'b1, 1'b0);

      sendEarly(8); padIdle();  checkBoth("all_early", 1'b0, 1'b1, 1'b0, 1'b1);
      sendLate(4);  sendEarly(4); padIdle(); checkBoth("net_zero", 1'b0, 1'b0, 1'b0, 1'b0);
      sendLate(5);  sendEarly(3); padIdle(); checkBoth("net_plus2", 1'b1, 1'b0, 1'b0, 1'b0);
      sendLate(6);  sendEarly(2); padIdle(); checkBoth("net_plus4", 1'b1, 1'b0, 1'b1, 1'b0);

      sendLate(4);
      repeat (3) padIdle();
      checkBoth("stretch_hold", 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) padIdle();
      sendLate(3);  checkBoth("stretch_open", 1'b0, 1'b0, 1'b0, 1'b0);
      sendLate(1);  padIdle();  checkBoth("stretch_close", 1'b1, 1'b0, 1'b1, 1'b0);

      sendLate(6);
      rst = 1'b1;
      #2 rst = 1'b0;
      sendLate(3);  checkBoth("post_rst_open", 1'b0, 1'b0, 1'b0, 1'b0);
      sendLate(5);  padIdle();  checkBoth("post_rst_close", 1'b1, 1'b0, 1'b1, 1'b0);

      sendLate(3);  sendNone(5); padIdle(); checkBoth("three_trans", 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef PD_STAT_EN
      checkCount("three_trans_tc", int'(tc0), 3);
`endif

      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 99) < 2) begin
            rst = 1'b1;
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            rst = 1'b0;
         end else begin
            applyStimulus(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
      end
      padIdle();
      padIdle();

      check_en = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
